// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator drain path.
// The ACC_DRAIN_RELU_EN macro is consumed by acc_requantizer.
package acc_pkg;
  localparam int ACC_WIDTH = 16;

  typedef enum logic [1:0] {
    BW2 = 2'd0,
    BW4 = 2'd1,
    BW8 = 2'd2
  } bitwidth_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_EMIT,
    S_FINISH
  } drain_state_e;

  function automatic int width_of(bitwidth_e bw);
    case (bw)
      BW4:     return 4;
      BW8:     return 8;
      default: return 2;
    endcase
  endfunction

  // Code 3 is not a real width; it folds onto 2b.
  function automatic bitwidth_e decode_bw(logic [1:0] raw);
    case (raw)
      2'd1:    return BW4;
      2'd2:    return BW8;
      default: return BW2;
    endcase
  endfunction
endpackage

// File: rtl/acc_requantizer.sv
// Combinational requantizer: round-half-up shift, clamp to active width, sign-extend.
// Define ACC_DRAIN_RELU_EN to clamp negatives to zero (fused ReLU).
module acc_requantizer
  import acc_pkg::*;
#(
  parameter int ACC_W = ACC_WIDTH,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       shift,
  input  bitwidth_e        bitwidth,
  output logic [OUT_W-1:0] q
);
  localparam int SW = ACC_W + 1;

  logic [SW-1:0]        bias;
  logic signed [SW-1:0] sum, r, hi, lo, c;

  always_comb begin
    // One guard bit keeps the rounding add from wrapping at the positive rail.
    bias = (shift != 4'd0) ? (SW'(1) << (shift - 4'd1)) : '0;
    sum  = $signed({acc[ACC_W-1], acc}) + $signed(bias);
    r    = sum >>> shift;
    hi   = SW'((1 << (width_of(bitwidth) - 1)) - 1);
`ifdef ACC_DRAIN_RELU_EN
    lo   = '0;
`else
    lo   = ~hi;
`endif
    if (r > hi)      c = hi;
    else if (r < lo) c = lo;
    else             c = r;
    q = OUT_W'(c);
  end
endmodule

// File: rtl/accumulator_drain.sv
// Drains the accumulator back buffer entry by entry into a valid/ready stream.
// ReLU clamping is selected at build time by ACC_DRAIN_RELU_EN (see acc_requantizer).
module accumulator_drain
  import acc_pkg::*;
#(
  parameter int BUFFER_WIDTH           = 8,
  parameter int SMALLEST_ELEMENT_WIDTH = 4,
  parameter int READ_LATENCY           = 1,
  parameter int OUT_WIDTH              = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [1:0]                          bitwidth,
  input  logic [3:0]                          shift,
  output logic [$clog2(BUFFER_WIDTH)-1:0]     bank_entry,
  input  logic [SMALLEST_ELEMENT_WIDTH*4-1:0] bank_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic [$clog2(BUFFER_WIDTH)-1:0]     out_index,
  output logic                                busy,
  output logic                                done
);
  localparam int            IW   = $clog2(BUFFER_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(BUFFER_WIDTH - 1);
  localparam logic [1:0]    LAT  = 2'(READ_LATENCY);

  drain_state_e   state, state_n;
  logic [IW-1:0]  entry;
  logic [1:0]     cnt;
  bitwidth_e      bw_q;
  logic [3:0]     sh_q;
  logic           latch, capture, advance;
  logic [OUT_WIDTH-1:0] q;

  acc_requantizer #(.ACC_W(SMALLEST_ELEMENT_WIDTH * 4), .OUT_W(OUT_WIDTH)) u_requant (
    .acc     (bank_data),
    .shift   (sh_q),
    .bitwidth(bw_q),
    .q       (q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        latch   = 1'b1;
        state_n = S_ADDR;
      end
      S_ADDR: if (LAT == 2'd0) begin
        capture = 1'b1;
        state_n = S_EMIT;
      end else begin
        state_n = S_WAIT;
      end
      // cnt reaching zero on this cycle means bank_data is now valid.
      S_WAIT: if (cnt == 2'd1) begin
        capture = 1'b1;
        state_n = S_EMIT;
      end
      S_EMIT: if (out_ready) begin
        if (entry == LAST) state_n = S_FINISH;
        else begin
          advance = 1'b1;
          state_n = S_ADDR;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry     <= '0;
      cnt       <= '0;
      bw_q      <= BW2;
      sh_q      <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      if (latch) begin
        entry <= '0;
        bw_q  <= decode_bw(bitwidth);
        sh_q  <= shift;
      end
      if (advance) entry <= entry + IW'(1);
      if (state == S_ADDR)      cnt <= LAT;
      else if (state == S_WAIT) cnt <= cnt - 2'd1;
      if (capture) begin
        out_data  <= q;
        out_index <= entry;
      end
    end
  end

  // Address and handshake outputs decode straight from registers, so they stay put in EMIT.
  assign bank_entry = entry;
  assign out_valid  = (state == S_EMIT);
  assign busy       = (state == S_ADDR) || (state == S_WAIT) || (state == S_EMIT);
  assign done       = (state == S_FINISH);
endmodule

// File: tb/tb_accumulator_drain.sv
// Scoreboard bench: one DUT at READ_LATENCY=1 for all scenarios, plus 0 and 3 for the basic drain.
module tb_accumulator_drain;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start_v;
  logic [1:0]  bitwidth;
  logic [3:0]  shift;
  logic        out_ready = 1'b1;
  logic [2:0]  bank_entry [3];
  logic [15:0] bank_data  [3];
  logic        out_valid  [3];
  logic [7:0]  out_data   [3];
  logic [2:0]  out_index  [3];
  logic        busy       [3];
  logic        done       [3];

  logic signed [15:0] mem [8];
  logic [15:0] p1, p3a, p3b, p3c;
  int q0[$], q1[$], q2[$];
  int n_cmp = 0, n_bad = 0;
  int done_cnt[3], hs_cnt[3], dc0[3], hc0[3];
  int v[8], e[8];
  int halt_idx = -1, stall_left = 0, n, dn;
  bit halted = 1'b0, stall_req = 1'b0, stall_done = 1'b0;
  logic [31:0] held, snap0;

  always #5 clk = ~clk;

  accumulator_drain #(.READ_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .bitwidth(bitwidth), .shift(shift),
    .bank_entry(bank_entry[0]), .bank_data(bank_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data[0]), .out_index(out_index[0]),
    .busy(busy[0]), .done(done[0]));
  accumulator_drain #(.READ_LATENCY(0)) u_lat0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .bitwidth(bitwidth), .shift(shift),
    .bank_entry(bank_entry[1]), .bank_data(bank_data[1]), .out_valid(out_valid[1]),
    .out_ready(1'b1), .out_data(out_data[1]), .out_index(out_index[1]),
    .busy(busy[1]), .done(done[1]));
  accumulator_drain #(.READ_LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .bitwidth(bitwidth), .shift(shift),
    .bank_entry(bank_entry[2]), .bank_data(bank_data[2]), .out_valid(out_valid[2]),
    .out_ready(1'b1), .out_data(out_data[2]), .out_index(out_index[2]),
    .busy(busy[2]), .done(done[2]));

  // Bank models with 1, 0 and 3 cycles of read latency.
  always @(posedge clk) begin
    p1  <= mem[bank_entry[0]];
    p3a <= mem[bank_entry[2]];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign bank_data[0] = p1;
  assign bank_data[1] = mem[bank_entry[1]];
  assign bank_data[2] = p3c;
  assign snap0 = {17'd0, out_valid[0], out_data[0], out_index[0], bank_entry[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(int acc, int sh, int bw);
    int w, a, hi, lo;
    w = (bw == 1) ? 4 : (bw == 2) ? 8 : 2;
    a = acc;
    if (sh > 0) a += 1 << (sh - 1);
    a = a >>> sh;
    hi = (1 << (w - 1)) - 1;
`ifdef ACC_DRAIN_RELU_EN
    lo = 0;
`else
    lo = -(1 << (w - 1));
`endif
    if (a > hi) a = hi;
    if (a < lo) a = lo;
    return a & 255;
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 8; i++) mem[i] = v[i][15:0];
  endtask

  task automatic model_exp(input int sh, input int bw);
    for (int i = 0; i < 8; i++) e[i] = ref_q(v[i], sh, bw);
  endtask

  task automatic push(input logic [2:0] which);
    for (int i = 0; i < 8; i++) begin
      if (which[0]) q0.push_back((i << 8) | (e[i] & 255));
      if (which[1]) q1.push_back((i << 8) | (e[i] & 255));
      if (which[2]) q2.push_back((i << 8) | (e[i] & 255));
    end
  endtask

  task automatic pop_chk(input int k);
    logic [31:0] got;
    int ex;
    got = {21'd0, out_index[k], out_data[k]};
    ex = -1;
    case (k)
      0: if (q0.size() > 0) ex = q0.pop_front();
      1: if (q1.size() > 0) ex = q1.pop_front();
      default: if (q2.size() > 0) ex = q2.pop_front();
    endcase
    chk($sformatf("d%0d_out", k), got, ex);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_entry"}, 32'(bank_entry[0]), 0);
    chk({tag, "_valid"}, 32'(out_valid[0]), 0);
    chk({tag, "_data"},  32'(out_data[0]), 0);
    chk({tag, "_index"}, 32'(out_index[0]), 0);
    chk({tag, "_busy"},  32'(busy[0]), 0);
    chk({tag, "_done"},  32'(done[0]), 0);
  endtask

  task automatic start_pass(input logic [2:0] which);
    for (int k = 0; k < 3; k++) begin
      dc0[k] = done_cnt[k];
      hc0[k] = hs_cnt[k];
    end
    @(negedge clk) start_v = which;
    @(negedge clk) start_v = 3'b000;
    if (which[0]) chk("busy_on_start", 32'(busy[0]), 1);
  endtask

  task automatic finish_pass(input logic [2:0] which, input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((busy[0] || busy[1] || busy[2]) && cyc < 600);
    if (cyc >= 600) chk({tag, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (which[k]) begin
        chk($sformatf("%s_done%0d", tag, k), done_cnt[k] - dc0[k], 1);
        chk($sformatf("%s_hs%0d", tag, k), hs_cnt[k] - hc0[k], 8);
      end
    end
  endtask

  // Monitor: drives out_ready for the main DUT (stall / halt) and scores every handshake.
  always @(negedge clk) begin
    halted = (halt_idx >= 0) &&
             (halted || (reset_n && out_valid[0] && int'(out_index[0]) == halt_idx));
    if (reset_n) begin
      if (stall_left > 0) begin
        chk("stall_hold", snap0, held);
        stall_left--;
      end else if (stall_req && !stall_done && out_valid[0] && out_index[0] == 3'd3) begin
        stall_done = 1'b1;
        stall_left = 5;
        held       = snap0;
      end
      out_ready = (stall_left == 0) && !halted;
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && (k != 0 || out_ready)) begin
          hs_cnt[k]++;
          pop_chk(k);
        end
        if (done[k]) done_cnt[k]++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    start_v  = 3'b000;
    bitwidth = 2'd0;
    shift    = 4'd0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;

    // 8b, no shift, all three latencies
    v = '{5, -3, 127, 128, -128, -129, 0, 1000};
    e = '{5, 253, 127, 127, 128, 128, 0, 127};
    load_mem();
    bitwidth = 2'd2;
    shift    = 4'd0;
    push(3'b111);
    start_pass(3'b111);
    finish_pass(3'b111, "s1");

    // 4b, shift 2, consumer stall on entry 3
    v = '{13, 30, -6, -40, -1, 32767, -32768, 2};
    model_exp(2, 1);
    e[0] = 3; e[1] = 7; e[2] = 8'hFF; e[3] = 8'hF8;
    load_mem();
    bitwidth  = 2'd1;
    shift     = 4'd2;
    stall_req = 1'b1;
    push(3'b001);
    start_pass(3'b001);
    finish_pass(3'b001, "s2");
    chk("stall_seen", 32'(stall_done), 1);
    stall_req = 1'b0;

    // code 3 folds to 2b; mid-pass start and config changes must be ignored
    v = '{3, -3, 5, -7, 100, -100, 1, -1};
    model_exp(1, 3);
    load_mem();
    bitwidth = 2'd3;
    shift    = 4'd1;
    push(3'b001);
    start_pass(3'b001);
    repeat (6) @(negedge clk);
    bitwidth = 2'd2;
    shift    = 4'd0;
    start_v  = 3'b001;
    @(negedge clk) start_v = 3'b000;
    finish_pass(3'b001, "s3");

    // async reset while holding entry 4 in EMIT
    v = '{5, -3, 127, 128, -128, -129, 0, 1000};
    e = '{5, 253, 127, 127, 128, 128, 0, 127};
    load_mem();
    bitwidth = 2'd2;
    shift    = 4'd0;
    push(3'b001);
    halt_idx = 4;
    start_pass(3'b001);
    n = 0;
    while (!halted && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (!halted) chk("halt_timeout", 0, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset("rst_mid");
    chk("q0_left", q0.size(), 4);
    q0.delete();
    dn = done_cnt[0];
    halt_idx = -1;
    repeat (3) @(negedge clk);
    chk("no_done", done_cnt[0], dn);
    reset_n = 1'b1;
    push(3'b001);
    start_pass(3'b001);
    finish_pass(3'b001, "s4");

    // 2b, no shift: ReLU build floors negatives at zero
    v = '{-5, 7, -1, 1, 2, -2, -3, 0};
    model_exp(0, 0);
`ifdef ACC_DRAIN_RELU_EN
    e[0] = 0;
`else
    e[0] = 8'hFE;
`endif
    e[1] = 1;
    load_mem();
    bitwidth = 2'd0;
    shift    = 4'd0;
    push(3'b001);
    start_pass(3'b001);
    finish_pass(3'b001, "s5");

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
